pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline-boundary register for the in-order RV32 core. It carries PC and instruction between adjacent stages, with the IF/ID boundary as the first user. It replaces ad-hoc stall/flush registers with a valid/ready handshake, an optional 2-entry skid buffer that keeps the upstream ready path registered, synchronous flush with NOP injection, and saturating stall/bubble performance counters.

## Interface
- `XLEN`, 32: PC width.
- `ILEN`, 32: instruction width.
- `SKID`, 1: 1 = 2-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- `NOP`, 32'h0000_0013: bubble instruction (`addi x0,x0,0`).
- `CNT_W`, 16: performance counter width.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: synchronous squash of all held and incoming entries.
- `cnt_clr` in 1: synchronous clear of both counters.
- `in_valid` in 1: upstream entry valid.
- `in_ready` out 1: stage can accept this cycle.
- `in_pc` in XLEN: upstream PC.
- `in_inst` in ILEN: upstream instruction.
- `out_valid` out 1: output entry valid.
- `out_ready` in 1: downstream consumes this cycle.
- `out_pc` out XLEN: held PC.
- `out_inst` out ILEN: held instruction; equals `NOP` whenever `out_valid`=0.
- `stall_cnt` out CNT_W: cycles with `out_valid && !out_ready`.
- `bubble_cnt` out CNT_W: cycles with `!out_valid`.

## Operation
- Accept = `in_valid && in_ready`. Consume = `out_valid && out_ready`.
- States (SKID=1): EMPTY (out invalid, skid empty), ONE (out valid, skid empty), TWO (out and skid valid).
  - EMPTY: accept -> out loads input, go ONE.
  - ONE, consume and accept: out loads input, stay ONE.
  - ONE, consume only: go EMPTY, `out_inst` <= NOP.
  - ONE, accept only: skid loads input, go TWO.
  - ONE, neither: hold.
  - TWO: `in_ready`=0. Consume -> out loads skid, go ONE. Otherwise hold.
- SKID=1: `in_ready` = !skid_valid (a pure register output).
- SKID=0: no skid and no TWO state; `in_ready` = `out_ready || !out_valid`.
- Flush has priority over all handshake activity. Next state is EMPTY, skid is cleared, `out_inst` <= NOP, and `out_pc` holds its value. Any input accepted in the flush cycle is discarded.
- Entries leave in arrival order. No entry is duplicated or dropped except by flush.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at all-ones; no wrap.
  - `cnt_clr` forces 0 and wins over increment.
  - Counters sample pre-edge `out_valid`/`out_ready` and ignore `flush`.

## Timing
- Reset values: `out_valid`=0, `out_pc`=0, `out_inst`=NOP, `in_ready`=1, skid empty, both counters 0.
- Latency: input accepted at edge N appears on `out_*` after edge N; throughput is 1 per cycle under continuous `out_ready`.
- `out_*` are registered and held stable while `out_valid && !out_ready`.
- SKID=1: a downstream stall is reflected in `in_ready` one cycle later. The skid absorbs the one in-flight entry.
- Flush at edge N: `out_valid`=0 and `in_ready`=1 after N. A new accept is possible at N+1.
- Reset asserted mid-transfer: all state returns to reset values immediately, with no wait for a clock edge.

## Structure
- `pipe_pkg` holds:
  - `NOP_INST` constant, 32'h0000_0013.
  - `stage_state_t` enum {EMPTY, ONE, TWO}.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `rst`, `clr`, `inc`, `q`), instantiated twice.
- Payload registers are plain flops. Only the valid bits and the state go through the enum FSM.

## Test plan
- Reset, then release with `in_valid`=0: `out_valid`=0, `out_inst`=32'h13, `in_ready`=1, and `bubble_cnt` counts 1, 2, 3… every cycle.
- Stream PCs 0x0, 0x4, 0x8 with instructions 0xA, 0xB, 0xC and `out_ready`=1: outputs appear 1 cycle later in order, one per cycle, `stall_cnt`=0.
- SKID=1: hold `out_ready`=0 while 2 entries are sent. `in_ready` drops after the 2nd accept. Release `out_ready`: both entries emerge in order, none lost, and `stall_cnt` equals the stall cycles.
- Stage in TWO; assert `flush` together with `out_ready`=1 and `in_valid`=1: next cycle `out_valid`=0, `out_inst`=32'h13, skid empty, and the input is discarded.
- Preload `stall_cnt` near max (CNT_W=4, stall 20 cycles): value sticks at 4'hF; `cnt_clr` -> 0 next cycle.
- Assert `rst` asynchronously mid-cycle while in TWO: outputs return to reset values before the next clock edge.
- Run all scenarios with SKID=0 as well, checking that `in_ready` follows `out_ready || !out_valid` combinationally.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the pipeline-boundary register.
package pipe_pkg;

    // Bubble instruction: addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Occupancy of the stage: output register and optional skid register
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    // Output register holds a live entry in every state but EMPTY
    function automatic logic state_out_valid(input stage_state_t s);
        return (s != EMPTY);
    endfunction

    // Skid register holds a live entry only in TWO
    function automatic logic state_skid_valid(input stage_state_t s);
        return (s == TWO);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of one pipeline boundary.
// master = the surrounding pipeline (producer and consumer side),
// slave  = the boundary register itself.
interface pipe_stage_reg_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    import pipe_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [ILEN-1:0] in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_inst;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst
    );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    import pipe_pkg::*;

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] ONE_LSB  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] q_r;

    // Count qualifying cycles and stick at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= '0;
        end else if (clr) begin
            q_r <= '0;
        end else if (inc && (q_r != ALL_ONES)) begin
            q_r <= q_r + ONE_LSB;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-boundary register carrying PC and instruction, with
// optional 2-entry skid buffer, flush with NOP injection and stall/bubble
// performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              XLEN  = 32,
    parameter int              ILEN  = 32,
    parameter int              SKID  = 1,
    parameter logic [ILEN-1:0] NOP   = NOP_INST,
    parameter int              CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 cnt_clr,
    pipe_stage_reg_if.slave      bus,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    stage_state_t    state_r;
    stage_state_t    state_s;
    logic            out_valid_r;
    logic            skid_valid_r;
    logic            in_ready_s;
    logic            accept_s;
    logic            consume_s;
    logic            load_out_s;
    logic            load_skid_s;
    logic            out_from_skid_s;
    logic            nop_out_s;
    logic [XLEN-1:0] out_pc_r;
    logic [ILEN-1:0] out_inst_r;
    logic [XLEN-1:0] skid_pc_r;
    logic [ILEN-1:0] skid_inst_r;

    // Handshake qualifiers; with a skid the upstream ready is a pure flop
    always_comb begin
        if (SKID != 0) begin
            in_ready_s = ~skid_valid_r;
        end else begin
            in_ready_s = bus.out_ready | ~out_valid_r;
        end
        accept_s  = bus.in_valid & in_ready_s;
        consume_s = out_valid_r & bus.out_ready;
    end

    // Next-state and payload steering; flush overrides every handshake
    always_comb begin
        state_s         = state_r;
        load_out_s      = 1'b0;
        load_skid_s     = 1'b0;
        out_from_skid_s = 1'b0;
        nop_out_s       = 1'b0;
        if (flush) begin
            state_s   = EMPTY;
            nop_out_s = 1'b1;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_s    = ONE;
                        load_out_s = 1'b1;
                    end else begin
                        state_s = EMPTY;
                    end
                end
                ONE: begin
                    if (consume_s && accept_s) begin
                        state_s    = ONE;
                        load_out_s = 1'b1;
                    end else if (consume_s) begin
                        state_s   = EMPTY;
                        nop_out_s = 1'b1;
                    end else if (accept_s && (SKID != 0)) begin
                        state_s     = TWO;
                        load_skid_s = 1'b1;
                    end else begin
                        state_s = ONE;
                    end
                end
                TWO: begin
                    if (consume_s) begin
                        state_s         = ONE;
                        out_from_skid_s = 1'b1;
                    end else begin
                        state_s = TWO;
                    end
                end
                default: begin
                    state_s   = EMPTY;
                    nop_out_s = 1'b1;
                end
            endcase
        end
    end

    // State and valid flags, registered together so both outputs are flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= EMPTY;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            out_valid_r  <= state_out_valid(state_s);
            skid_valid_r <= state_skid_valid(state_s);
        end
    end

    // Output payload; PC is kept on NOP injection so it still names the last slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pc_r   <= '0;
            out_inst_r <= NOP;
        end else if (nop_out_s) begin
            out_inst_r <= NOP;
        end else if (load_out_s) begin
            out_pc_r   <= bus.in_pc;
            out_inst_r <= bus.in_inst;
        end else if (out_from_skid_s) begin
            out_pc_r   <= skid_pc_r;
            out_inst_r <= skid_inst_r;
        end
    end

    // Skid payload catches the one entry in flight when downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_pc_r   <= '0;
            skid_inst_r <= NOP;
        end else if (load_skid_s) begin
            skid_pc_r   <= bus.in_pc;
            skid_inst_r <= bus.in_inst;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_pc    = out_pc_r;
    assign bus.out_inst  = out_inst_r;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (out_valid_r & ~bus.out_ready),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (~out_valid_r),
        .q   (bubble_cnt)
    );

endmodule
